// File: rtl/hazard_stall_controller.sv
// Pipeline hazard / stall controller.
// Freezes the whole pipeline for MEM_WAIT_CYCLES cycles on each data-memory
// access. It also resolves data hazards in ID and flushes on taken branches.
// Optional macro FORWARDING_EN: when defined, only load-use hazards against
// EXE stall, because the datapath forwards all other results.
module hazard_stall_controller #(
  parameter int MEM_WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        mem_req,
  input  logic        branch_taken,
  output logic        freeze_pc,
  output logic        freeze_if_id,
  output logic        bubble_id,
  output logic        flush,
  output logic        freeze_all,
  output logic        mem_ready,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, MEM_BUSY, MEM_DONE} state_t;

  // The IDLE request cycle and the final MEM_BUSY cycle at cnt==0 are both
  // frozen, so the counter is loaded two short of the wait length.
  localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT_CYCLES - 2);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] stall_q;
  logic        hazard;
  logic        frz_all_c, rdy_c, fpc_c, fifid_c, bub_c, flush_c;

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time.
  assign hazard = exe_mem_read & exe_wb_en &
                  ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
  logic unused_mem_in;
  assign unused_mem_in = ^{mem_dest, mem_wb_en};
`else
  // Without forwarding, any pending write in EXE or MEM blocks the ID read.
  assign hazard = (exe_wb_en & ((src1 == exe_dest) | (two_src & (src2 == exe_dest)))) |
                  (mem_wb_en & ((src1 == mem_dest) | (two_src & (src2 == mem_dest))));
  logic unused_exe_rd;
  assign unused_exe_rd = exe_mem_read;
`endif

  // Memory-access FSM: next state, counter and freeze/ready flags.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    frz_all_c = 1'b0;
    rdy_c     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          frz_all_c = 1'b1;
          state_nxt = MEM_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      MEM_BUSY: begin
        frz_all_c = 1'b1;
        if (cnt == 4'd0) state_nxt = MEM_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      MEM_DONE: begin
        rdy_c     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control priority: memory freeze, then taken branch, then data hazard.
  always_comb begin
    fpc_c   = 1'b0;
    fifid_c = 1'b0;
    bub_c   = 1'b0;
    flush_c = 1'b0;
    if (frz_all_c) begin
      fpc_c   = 1'b1;
      fifid_c = 1'b1;
    end else if (branch_taken) begin
      flush_c = 1'b1;
    end else if (hazard) begin
      fpc_c   = 1'b1;
      fifid_c = 1'b1;
      bub_c   = 1'b1;
    end
  end

  // All outputs are held low while reset is asserted.
  assign freeze_all   = ~rst & frz_all_c;
  assign mem_ready    = ~rst & rdy_c;
  assign freeze_pc    = ~rst & fpc_c;
  assign freeze_if_id = ~rst & fifid_c;
  assign bubble_id    = ~rst & bub_c;
  assign flush        = ~rst & flush_c;
  assign stall_cycles = rst ? 16'h0 : stall_q;

  // State register, wait counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      stall_q <= 16'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fpc_c && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

endmodule
